rom_arbiter: RTL
================

Name: rom_arbiter

Overview:
- Round-robin arbiter that shares one synchronous read-only ROM (read strobe, 4-bit address, 4-bit registered data) among NUM_REQ requesters.
- Accepts one read request at a time, drives the ROM read/address for one cycle, and waits the ROM's fixed read latency.
- Returns the captured data to the winner, tagged with its requester ID.
- Sits between client blocks and the single rom instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 4, ROM address width.
- DATA_W, 4, ROM data width.
- ROM_LAT, 1, cycles from the clock edge sampling rom_read=1 to rom_data_out valid (1..4).
- ID_W, $clog2(NUM_REQ) (minimum 1), requester ID width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until accepted.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot accept; request i accepted when req_valid[i]&req_ready[i].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  DATA_W  ROM word for the response.
- rom_read  out  1  ROM read strobe.
- rom_address  out  ADDR_W  ROM address.
- rom_data_out  in  DATA_W  ROM read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- Reset (synchronous, any state):
  - state=IDLE; rom_read=0, rom_address=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has first priority.
  - req_ready forced 0 while rst=1.
  - Any in-flight transaction is dropped; no response is issued for it.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first asserted req_valid, searching from last+1 upward with wrap.
  - On an edge with any req_valid: latch winner ID and its req_addr, set last=winner, go to ISSUE.
  - With no req_valid: req_ready=0 and the state is held.
- ISSUE (exactly 1 cycle):
  - rom_read=1, rom_address=latched address.
  - Next state is WAIT, with the latency counter cleared.
- WAIT (exactly ROM_LAT cycles):
  - rom_read=0; rom_address holds its last value.
  - On the final WAIT edge: rsp_data<=rom_data_out, rsp_id<=latched ID, rsp_valid<=1, state<=IDLE.
- rsp_valid is high for exactly one cycle. There is no backpressure; consumers must sample in that cycle.
- Latency: the acceptance edge is T0, rsp_valid is high in the cycle after edge T0+1+ROM_LAT.
  - For ROM_LAT=1, rsp_valid is high 2 cycles after acceptance.
- Throughput: one accept every 2+ROM_LAT cycles.
  - The cycle in which rsp_valid is high is already IDLE and may accept the next request.
- req_ready is 0 in ISSUE and WAIT regardless of req_valid.
- A requester dropping req_valid before acceptance is legal and has no side effects.
- Address 2^ADDR_W-1 is passed unchanged; there is no address arithmetic.
- The RR pointer advances only on acceptance, never on reset release or idle cycles.
- Simultaneous rsp_valid and new acceptance in the same cycle is legal; both occur.

Decomposition:
- Package rom_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - default width constants (ADDR_W=4, DATA_W=4);
  - a function computing ID_W from NUM_REQ.
- Sub-module rr_arbiter (combinational): inputs are the request vector and last pointer; outputs are the one-hot grant and encoded index. It is reused by future shared-resource controllers.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, rom_read=0, rsp_valid=0, busy=0 throughout. After release, the first grant goes to requester 0.
- Single request: req_valid[2]=1, addr=5 -> req_ready=4'b0100 for one cycle, then rom_read=1 with rom_address=5 for one cycle. rsp_valid then pulses with rsp_id=2 and rsp_data equal to ROM[5].
- All four requesting continuously, addresses 0,1,2,3 -> grant order 0,1,2,3,0, one accept every 3 cycles, each rsp_data equal to ROM[i].
- Fairness: req_valid[1] and req_valid[3] held high -> grants alternate 1,3,1,3; requesters 0 and 2 never receive req_ready.
- Reset during WAIT: rst asserted one cycle after ISSUE -> no rsp_valid pulse. The next grant with all requesting goes to requester 0.
- ROM_LAT=2 build, requester 1 at address 15 -> rsp_valid pulse 3 cycles after acceptance with rsp_data=ROM[15]; the next accept occurs no earlier than 4 cycles after the first.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM arbiter and related controllers.
package rom_arb_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;

  // Width needed to encode a requester index; never below one bit.
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Client-side request/response bundle of the ROM arbiter.
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = id_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;

  // Clients drive requests and consume grants/responses.
  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // The arbiter consumes requests and drives grants/responses.
  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after 'last', wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  logic found_s;
  int   cand_s;

  // Scan from last+1 upward with wrap; the first asserted request wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s = (int'(last_i) + off) % NUM_REQ;
      if (!found_s && req_i[cand_s]) begin
        found_s        = 1'b1;
        gnt_o[cand_s]  = 1'b1;
        idx_o          = ID_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one fixed-latency synchronous ROM among NUM_REQ clients.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = 1,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  rom_arbiter_if.slave       bus,
  output logic               rom_read,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [DATA_W-1:0]  rom_data_out,
  output logic               busy
);

  localparam int            CNT_W    = 3;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ROM_LAT - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rom_read_q, rom_read_d;
  logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] win_gnt_s;
  logic [ID_W-1:0]    win_idx_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .gnt_o  (win_gnt_s),
    .idx_o  (win_idx_s)
  );

  // Grants are only offered while idle and out of reset.
  assign bus.req_ready = (!rst && (state_q == IDLE)) ? win_gnt_s : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign rom_read      = rom_read_q;
  assign rom_address   = rom_address_q;
  assign busy          = busy_q;

  // Next-state: accept in IDLE, strobe ROM in ISSUE, collect data at end of WAIT.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          state_d = ISSUE;
          last_d  = win_idx_s;
          id_d    = win_idx_s;
          addr_d  = bus.req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = rom_data_out;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered versions of what the next state implies.
    rom_read_d    = (state_d == ISSUE);
    rom_address_d = (state_d == ISSUE) ? addr_d : rom_address_q;
    busy_d        = (state_d != IDLE);
  end

  // State and output registers with synchronous reset that drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= ID_W'(NUM_REQ - 1);
      id_q          <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      rom_read_q    <= 1'b0;
      rom_address_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      rom_read_q    <= rom_read_d;
      rom_address_q <= rom_address_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      busy_q        <= busy_d;
    end
  end

endmodule
